fft_stream_out: RTL and testbench
=================================

FFT_STREAM_OUT -- requirements
Module: fft_stream_out

Interface
REQ-001 The block SHALL have parameter FFT_LEN, default 64, meaning points per frame; a power of two, 2..1024.
REQ-002 The block SHALL have parameter DATA_WID, default 16, meaning bits per real or imaginary sample (two's complement).
REQ-003 The block SHALL have parameter IDX_WID, default 6, meaning log2(FFT_LEN).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port done_i, input, 1 bit: the FFT core's one-cycle frame-complete strobe.
REQ-007 The block SHALL have port fft_data_re_i, input, FFT_LEN*DATA_WID bits: parallel real frame, valid only while done_i=1.
REQ-008 The block SHALL have port fft_data_im_i, input, FFT_LEN*DATA_WID bits: parallel imaginary frame, valid only while done_i=1.
REQ-009 The block SHALL have port m_valid_o, output, 1 bit: the stream sample is valid.
REQ-010 The block SHALL have port m_ready_i, input, 1 bit: the downstream sink accepts the sample.
REQ-011 The block SHALL have port m_re_o, output, DATA_WID bits: the streamed real sample.
REQ-012 The block SHALL have port m_im_o, output, DATA_WID bits: the streamed imaginary sample.
REQ-013 The block SHALL have port m_idx_o, output, IDX_WID bits: the frequency-bin index of the current sample.
REQ-014 The block SHALL have port m_last_o, output, 1 bit: the current sample is bin FFT_LEN-1.
REQ-015 The block SHALL have port busy_o, output, 1 bit: a frame is held and still being streamed.
REQ-016 The block SHALL have port ovf_o, output, 1 bit: sticky flag meaning a frame was dropped.
REQ-017 The block SHALL have port clr_ovf_i, input, 1 bit: synchronous clear of ovf_o.
REQ-018 The block SHALL have port frame_cnt_o, output, 16 bits: count of fully streamed frames, wrapping.

Function
REQ-019 The block SHALL implement a two-state FSM with states IDLE and SEND.
REQ-020 In IDLE, done_i=1 SHALL capture both input buses into internal frame registers, set the index to 0, and move the FSM to SEND on the next edge.
REQ-021 Latency SHALL be one cycle: with done_i high in cycle N, m_valid_o SHALL be 1 in cycle N+1 with m_idx_o=0.
REQ-022 Sample k SHALL be bits [(k+1)*DATA_WID-1 : k*DATA_WID] of the captured bus, for both re and im.
REQ-023 In SEND, m_valid_o SHALL be 1 and m_re_o, m_im_o and m_idx_o SHALL present sample idx.
REQ-024 A transfer SHALL occur exactly when m_valid_o=1 and m_ready_i=1; each transfer SHALL increment the index by 1.
REQ-025 While m_valid_o=1 and m_ready_i=0, m_re_o, m_im_o, m_idx_o and m_last_o SHALL hold stable.
REQ-026 m_valid_o SHALL NOT depend combinationally on m_ready_i.
REQ-027 m_last_o SHALL be 1 when idx=FFT_LEN-1 and m_valid_o=1, and 0 otherwise.
REQ-028 The transfer of idx=FFT_LEN-1 SHALL increment frame_cnt_o (wrapping 0xFFFF to 0) and return the FSM to IDLE.
REQ-029 If done_i=1 in the same cycle as the last transfer, the new frame SHALL be captured and the FSM SHALL stay in SEND with idx=0, giving a gapless frame-to-frame stream.
REQ-030 If done_i=1 in SEND in any cycle other than the last transfer, the new frame SHALL be dropped, the held frame SHALL be unaffected, and ovf_o SHALL be set on the next edge.
REQ-031 clr_ovf_i=1 SHALL clear ovf_o on the next edge; a simultaneous set condition SHALL take priority, leaving ovf_o=1.
REQ-032 busy_o SHALL equal (state==SEND).
REQ-033 When m_valid_o=0, m_re_o, m_im_o, m_idx_o and m_last_o SHALL be 0.
REQ-034 With m_ready_i held at 1, a full frame SHALL stream in exactly FFT_LEN consecutive cycles.

Reset
REQ-035 While rst_n=0, the FSM SHALL be in IDLE, and idx, m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o, busy_o, ovf_o and frame_cnt_o SHALL all be 0.
REQ-036 A reset asserted mid-frame SHALL abandon the held frame; after release, no stale sample SHALL be emitted until the next done_i.
REQ-037 The captured frame registers are not required to have a reset value.

Verification
REQ-038 The bench SHALL cover: ramp frame (re[k]=k, im[k]=-k), done_i pulse, m_ready_i=1 -> valid from the next cycle for 64 cycles, idx 0..63, last only at idx 63, frame_cnt_o=1.
REQ-039 The bench SHALL cover: same frame with m_ready_i toggling randomly at 50% -> 64 transfers in order, outputs stable during stalls, no duplicates or skips.
REQ-040 The bench SHALL cover: done_i during the last transfer with a second frame (re[k]=100+k) -> idx 63 of frame 1 followed directly by idx 0 re=100, no bubble, frame_cnt_o=2 after both frames.
REQ-041 The bench SHALL cover: done_i at idx 10 of frame 1 -> frame 1 completes unchanged, ovf_o=1 from the next cycle; clr_ovf_i pulse -> ovf_o=0.
REQ-042 The bench SHALL cover: rst_n pulsed low at idx 30 -> all outputs 0 immediately; after release, m_valid_o=0 until a new done_i.
REQ-043 The bench SHALL cover: 65536 frames streamed -> frame_cnt_o wraps to 0.

Source files
------------

// File: rtl/fft_stream_out.sv
// ---------------------------------------------------------------------------
// fft_stream_out : serialises a parallel FFT result frame onto a valid/ready
//                  stream, one frequency bin per transfer.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_stream_out #(
  parameter int FFT_LEN  = 64,
  parameter int DATA_WID = 16,
  parameter int IDX_WID  = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         done_i,
  input  logic [FFT_LEN*DATA_WID-1:0]  fft_data_re_i,
  input  logic [FFT_LEN*DATA_WID-1:0]  fft_data_im_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [DATA_WID-1:0]          m_re_o,
  output logic [DATA_WID-1:0]          m_im_o,
  output logic [IDX_WID-1:0]           m_idx_o,
  output logic                         m_last_o,
  output logic                         busy_o,
  output logic                         ovf_o,
  input  logic                         clr_ovf_i,
  output logic [15:0]                  frame_cnt_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(FFT_LEN - 1);

  logic [0:0]          state_q, state_d;
  logic [IDX_WID-1:0]  idx_q, idx_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [DATA_WID-1:0] frame_re_q [FFT_LEN];
  logic [DATA_WID-1:0] frame_re_d [FFT_LEN];
  logic [DATA_WID-1:0] frame_im_q [FFT_LEN];
  logic [DATA_WID-1:0] frame_im_d [FFT_LEN];

  logic capture;
  logic sending;
  logic xfer;
  logic at_last;

  assign sending = (state_q == SEND);
  assign xfer    = sending && m_ready_i;
  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    capture     = 1'b0;

    if (clr_ovf_i) ovf_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (done_i) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      default: begin
        if (xfer) idx_d = idx_q + IDX_WID'(1);
        if (xfer && at_last) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          // A new frame arriving exactly on the final transfer chains on gaplessly.
          if (done_i) begin
            capture = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (done_i) begin
          // Set wins over a simultaneous clear, so the drop is never lost.
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < FFT_LEN; k++) begin
      frame_re_d[k] = capture ? fft_data_re_i[k*DATA_WID +: DATA_WID] : frame_re_q[k];
      frame_im_d[k] = capture ? fft_data_im_i[k*DATA_WID +: DATA_WID] : frame_im_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frame storage is data-path only; the FSM reset alone keeps it from being emitted.
  always_ff @(posedge clk) begin
    frame_re_q <= frame_re_d;
    frame_im_q <= frame_im_d;
  end

  assign m_valid_o   = sending;
  assign m_re_o      = sending ? frame_re_q[idx_q] : '0;
  assign m_im_o      = sending ? frame_im_q[idx_q] : '0;
  assign m_idx_o     = sending ? idx_q : '0;
  assign m_last_o    = sending && at_last;
  assign busy_o      = sending;
  assign ovf_o       = ovf_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_stream_out.sv
// ---------------------------------------------------------------------------
// tb_fft_stream_out : directed self-checking bench for fft_stream_out.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_stream_out;

  localparam int FFT_LEN  = 64;
  localparam int DATA_WID = 16;
  localparam int IDX_WID  = 6;
  localparam int BW       = FFT_LEN * DATA_WID;

  logic                clk;
  logic                rst_n;
  logic                done_i;
  logic [BW-1:0]       re_bus;
  logic [BW-1:0]       im_bus;
  logic                m_valid_o;
  logic                m_ready_i;
  logic [DATA_WID-1:0] m_re_o;
  logic [DATA_WID-1:0] m_im_o;
  logic [IDX_WID-1:0]  m_idx_o;
  logic                m_last_o;
  logic                busy_o;
  logic                ovf_o;
  logic                clr_ovf_i;
  logic [15:0]         frame_cnt_o;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  fft_stream_out #(.FFT_LEN(FFT_LEN), .DATA_WID(DATA_WID), .IDX_WID(IDX_WID)) dut (
    .clk(clk), .rst_n(rst_n), .done_i(done_i),
    .fft_data_re_i(re_bus), .fft_data_im_i(im_bus),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_re_o(m_re_o), .m_im_o(m_im_o), .m_idx_o(m_idx_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i), .frame_cnt_o(frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample k of a frame is base + step*k, truncated to DATA_WID.
  function automatic logic [BW-1:0] mk_bus(input int base, input int step);
    logic [BW-1:0] b;
    for (int k = 0; k < FFT_LEN; k++) b[k*DATA_WID +: DATA_WID] = DATA_WID'(base + step * k);
    return b;
  endfunction

  task automatic test_reset();
    total++;
    if ({m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o, busy_o, ovf_o, frame_cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset: valid=%b re=%h im=%h idx=%0d last=%b busy=%b ovf=%b cnt=%0d, want all 0",
               m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o, busy_o, ovf_o, frame_cnt_o);
    end
  endtask

  task automatic test_ramp();
    m_ready_i = 1'b1;
    re_bus = mk_bus(0, 1); im_bus = mk_bus(0, -1); done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0; re_bus = mk_bus(500, 3); im_bus = mk_bus(700, 5);
    for (int k = 0; k < FFT_LEN; k++) begin
      total++;
      if (m_valid_o !== 1'b1 || busy_o !== 1'b1 || m_idx_o !== IDX_WID'(k) || m_re_o !== DATA_WID'(k) ||
          m_im_o !== DATA_WID'(-k) || m_last_o !== (k == FFT_LEN - 1)) begin
        bad++;
        $display("FAIL ramp k=%0d: valid=%b busy=%b idx=%0d re=%h im=%h last=%b, want idx=%0d re=%h im=%h",
                 k, m_valid_o, busy_o, m_idx_o, m_re_o, m_im_o, m_last_o, k, DATA_WID'(k), DATA_WID'(-k));
      end
      @(negedge clk);
    end
    exp_cnt++;
    total++;
    if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || m_idx_o !== '0 || frame_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL ramp_end: valid=%b busy=%b idx=%0d cnt=%0d, want valid=0 busy=0 idx=0 cnt=%0d",
               m_valid_o, busy_o, m_idx_o, frame_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int cyc = 0;
    logic rdy;
    m_ready_i = 1'b0;
    re_bus = mk_bus(0, 1); im_bus = mk_bus(0, -1); done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0; re_bus = mk_bus(500, 3); im_bus = mk_bus(700, 5);
    while (k < FFT_LEN && cyc < 2000) begin
      total++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IDX_WID'(k) || m_re_o !== DATA_WID'(k) ||
          m_im_o !== DATA_WID'(-k) || m_last_o !== (k == FFT_LEN - 1)) begin
        bad++;
        $display("FAIL stall k=%0d: valid=%b idx=%0d re=%h im=%h last=%b, want idx=%0d re=%h im=%h",
                 k, m_valid_o, m_idx_o, m_re_o, m_im_o, m_last_o, k, DATA_WID'(k), DATA_WID'(-k));
      end
      rdy = 1'($urandom_range(0, 1));
      m_ready_i = rdy;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    m_ready_i = 1'b0;
    exp_cnt++;
    total++;
    if (cyc >= 2000 || m_valid_o !== 1'b0 || frame_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL stall_end: transfers=%0d cycles=%0d valid=%b cnt=%0d, want 64 transfers valid=0 cnt=%0d",
               k, cyc, m_valid_o, frame_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    m_ready_i = 1'b1;
    re_bus = mk_bus(0, 1); im_bus = mk_bus(0, -1); done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0; re_bus = mk_bus(500, 3); im_bus = mk_bus(700, 5);
    for (int k = 0; k < 2 * FFT_LEN; k++) begin
      int s = k % FFT_LEN;
      logic [DATA_WID-1:0] e_re = (k < FFT_LEN) ? DATA_WID'(s) : DATA_WID'(100 + s);
      logic [DATA_WID-1:0] e_im = (k < FFT_LEN) ? DATA_WID'(-s) : DATA_WID'(200 + 2 * s);
      total++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IDX_WID'(s) || m_re_o !== e_re || m_im_o !== e_im ||
          m_last_o !== (s == FFT_LEN - 1)) begin
        bad++;
        $display("FAIL b2b n=%0d: valid=%b idx=%0d re=%h im=%h last=%b, want idx=%0d re=%h im=%h",
                 k, m_valid_o, m_idx_o, m_re_o, m_im_o, m_last_o, s, e_re, e_im);
      end
      if (k == FFT_LEN - 1) begin
        re_bus = mk_bus(100, 1); im_bus = mk_bus(200, 2); done_i = 1'b1;
      end
      @(negedge clk);
      done_i = 1'b0; re_bus = mk_bus(500, 3); im_bus = mk_bus(700, 5);
      if (k == FFT_LEN - 1) begin
        exp_cnt++;
        total++;
        if (frame_cnt_o !== 16'(exp_cnt)) begin
          bad++;
          $display("FAIL b2b_cnt1: cnt=%0d, want %0d", frame_cnt_o, exp_cnt);
        end
      end
    end
    exp_cnt++;
    total++;
    if (m_valid_o !== 1'b0 || frame_cnt_o !== 16'(exp_cnt) || ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: valid=%b cnt=%0d ovf=%b, want valid=0 cnt=%0d ovf=0",
               m_valid_o, frame_cnt_o, ovf_o, exp_cnt);
    end
  endtask

  task automatic test_overflow();
    m_ready_i = 1'b1;
    re_bus = mk_bus(0, 1); im_bus = mk_bus(0, -1); done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0; re_bus = mk_bus(500, 3); im_bus = mk_bus(700, 5);
    for (int k = 0; k < FFT_LEN; k++) begin
      total++;
      if (m_valid_o !== 1'b1 || m_idx_o !== IDX_WID'(k) || m_re_o !== DATA_WID'(k) ||
          m_im_o !== DATA_WID'(-k) || ovf_o !== (k > 10)) begin
        bad++;
        $display("FAIL ovf k=%0d: valid=%b idx=%0d re=%h im=%h ovf=%b, want idx=%0d re=%h im=%h ovf=%b",
                 k, m_valid_o, m_idx_o, m_re_o, m_im_o, ovf_o, k, DATA_WID'(k), DATA_WID'(-k), k > 10);
      end
      // Drop at idx 10; at idx 20 a drop coincides with a clear, and the set must win.
      done_i    = (k == 10) || (k == 20);
      clr_ovf_i = (k == 20);
      @(negedge clk);
      done_i = 1'b0; clr_ovf_i = 1'b0;
    end
    exp_cnt++;
    total++;
    if (m_valid_o !== 1'b0 || ovf_o !== 1'b1 || frame_cnt_o !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL ovf_end: valid=%b ovf=%b cnt=%0d, want valid=0 ovf=1 cnt=%0d",
               m_valid_o, ovf_o, frame_cnt_o, exp_cnt);
    end
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    total++;
    if (ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: ovf=%b, want 0", ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    m_ready_i = 1'b1;
    re_bus = mk_bus(0, 1); im_bus = mk_bus(0, -1); done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (m_valid_o !== 1'b1 || m_idx_o !== IDX_WID'(30) || m_re_o !== DATA_WID'(30)) begin
      bad++;
      $display("FAIL rst_mid_pre: valid=%b idx=%0d re=%h, want valid=1 idx=30 re=001e", m_valid_o, m_idx_o, m_re_o);
    end
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++;
    if ({m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o, busy_o, ovf_o, frame_cnt_o} !== '0) begin
      bad++;
      $display("FAIL rst_mid: valid=%b re=%h im=%h idx=%0d last=%b busy=%b ovf=%b cnt=%0d, want all 0",
               m_valid_o, m_re_o, m_im_o, m_idx_o, m_last_o, busy_o, ovf_o, frame_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || m_re_o !== '0) begin
        bad++;
        $display("FAIL rst_stale c=%0d: valid=%b busy=%b re=%h, want 0 0 0000", i, m_valid_o, busy_o, m_re_o);
      end
    end
  endtask

  task automatic test_wrap();
    // Preload the count just below the wrap point rather than streaming 65535 frames.
    m_ready_i = 1'b1;
    force dut.frame_cnt_d = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_d;
    total++;
    if (frame_cnt_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: cnt=%h, want ffff", frame_cnt_o);
    end
    re_bus = mk_bus(0, 1); im_bus = mk_bus(0, -1); done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    repeat (FFT_LEN) @(negedge clk);
    total++;
    if (frame_cnt_o !== 16'h0000 || m_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap: cnt=%h valid=%b, want cnt=0000 valid=0", frame_cnt_o, m_valid_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; done_i = 1'b0; m_ready_i = 1'b0; clr_ovf_i = 1'b0;
    re_bus = '0; im_bus = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_ramp();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_ramp();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
